// File: rtl/day_10_pkg.sv
// Shared types and constants for the self-reloading up-counter.
package day_10_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage : day_10_pkg

// File: rtl/day_10.sv
// Self-reloading up-counter: a load captures the start value, and on reaching
// all-ones the count restarts from that captured value instead of zero.
module day_10
  import day_10_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;

  // Load outranks self-reload, so a load on the all-ones cycle takes the new value.
  always_comb begin
    cnt_d = cnt_q;
    rld_d = rld_q;
    if (load_i) begin
      cnt_d = load_val_i;
      rld_d = load_val_i;
    end else if (cnt_q == MAX_VAL) begin
      cnt_d = rld_q;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      rld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rld_q <= rld_d;
    end
  end

  assign count_o = cnt_q;

endmodule : day_10

// File: tb/tb_day_10.sv
// Directed, scoreboard-driven bench for the self-reloading up-counter.
module tb_day_10;

  logic       clk;
  logic       reset;
  logic       load_i;
  logic [3:0] load_val_i;
  logic [3:0] count_o;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_cnt;
  logic [3:0] m_rld;
  logic [3:0] exp_q[$];

  day_10 #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [3:0] expected);
    total++;
    assert (count_o === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: count_o=%0d expected=%0d", tag, count_o, expected);
    end
  endtask

  // Drive one cycle from a negedge, advance the reference model, and score the result.
  task automatic applyStimulus(input bit ld, input logic [3:0] val, input string tag);
    logic [3:0] expected;
    load_i     = ld;
    load_val_i = val;
    if (ld) begin
      m_cnt = val;
      m_rld = val;
    end else if (m_cnt == 4'hF) begin
      m_cnt = m_rld;
    end else begin
      m_cnt = m_cnt + 4'd1;
    end
    exp_q.push_back(m_cnt);
    @(posedge clk);
    @(negedge clk);
    expected = exp_q.pop_front();
    checkOutput(tag, expected);
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 4'($urandom_range(0, 15)), tag);
  endtask

  initial begin
    reset      = 1'b0;
    load_i     = 1'b0;
    load_val_i = 4'd0;
    m_cnt      = 4'd0;
    m_rld      = 4'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", 4'd0);
    reset = 1'b1;
    checkOutput("post_release", 4'd0);

    runCycles(17, "free_run_from_zero");

    applyStimulus(1'b1, 4'd3, "load_3");
    runCycles(14, "reload_to_3");

    applyStimulus(1'b1, 4'd6, "load_6");
    runCycles(20, "period_10");

    applyStimulus(1'b1, 4'd2, "load_2");
    runCycles(13, "count_to_max");
    applyStimulus(1'b1, 4'd9, "load_beats_reload");
    runCycles(3, "after_load_9");

    applyStimulus(1'b1, 4'd5, "b2b_load_a");
    applyStimulus(1'b1, 4'd11, "b2b_load_b");
    runCycles(2, "b2b_resume");

    applyStimulus(1'b1, 4'd15, "load_max");
    runCycles(20, "hold_at_max");
    applyStimulus(1'b1, 4'd0, "load_0");
    runCycles(3, "count_from_0");

    for (int i = 0; i < 20 && m_cnt != 4'd7; i++)
      applyStimulus(1'b1, 4'd4, "approach_7");
    for (int i = 0; i < 3; i++) begin
      if (m_cnt != 4'd7) applyStimulus(1'b0, 4'd0, "approach_7");
    end
    checkOutput("at_7_before_reset", 4'd7);

    #2;
    reset = 1'b0;
    m_cnt = 4'd0;
    m_rld = 4'd0;
    #1;
    checkOutput("async_reset_immediate", 4'd0);
    @(posedge clk);
    #1;
    checkOutput("held_in_reset", 4'd0);
    @(negedge clk);
    reset = 1'b1;
    runCycles(18, "reload_cleared_to_0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_day_10
